// File: rtl/updown_counter_mod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_mod_pkg
// Description : Shared constants and helpers for the parametrised up/down
//               counter: count-mode and direction encodings, plus the
//               range-clamp decision used when a value is loaded.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package updown_counter_mod_pkg;

    // Bound behaviour selected by the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Encoding of the up_down input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Values are compared at a fixed 33-bit width so that one function
    // serves every counter width (up to 32 bits) without truncation.
    localparam int CLAMP_W = 33;

    typedef enum logic [1:0] {
        CLAMP_PASS   = 2'd0,
        CLAMP_TO_MIN = 2'd1,
        CLAMP_TO_MAX = 2'd2
    } clamp_e;

    // Decides how a requested load value must be forced into [lo..hi].
    function automatic clamp_e clamp_sel(
        input logic [CLAMP_W-1:0] val,
        input logic [CLAMP_W-1:0] lo,
        input logic [CLAMP_W-1:0] hi
    );
        if (val > hi) begin
            return CLAMP_TO_MAX;
        end
        if (val < lo) begin
            return CLAMP_TO_MIN;
        end
        return CLAMP_PASS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/udcnt_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : udcnt_prescaler
// Description : Enable-gated tick generator. Emits one tick on every
//               PRESCALE-th cycle that en is high; clr restarts the phase.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-high reset
//               clr   - synchronous phase restart (suppresses tick)
//               en    - advance enable
//               tick  - one-cycle step strobe
// Revision    : 1.0 - initial release
// ============================================================================
module udcnt_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_phase;
    logic             w_last;

    assign w_last = (r_phase == C_LAST);
    assign tick   = en & ~clr & w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
        end else if (clr) begin
            r_phase <= '0;
        end else if (en) begin
            r_phase <= w_last ? '0 : r_phase + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/updown_counter_mod.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_mod
// Description : Parametrised up/down counter over [MIN_VAL..MAX_VAL] with
//               wrap or saturate behaviour, synchronous clear, clamped
//               parallel load, terminal-count decodes and a registered
//               bound-event pulse.
//               Optional feature macro UPDOWN_COUNTER_MOD_PRESCALE_EN adds a
//               PRESCALE parameter: the count steps only on every PRESCALE-th
//               enabled cycle.
// Ports       : clk, reset (async, active-high)
//               clear, load, load_val, en, up_down - control inputs
//               count       - registered count value
//               at_max      - count == MAX_VAL
//               at_min      - count == MIN_VAL
//               event_pulse - registered wrap / blocked-step pulse
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_mod
    import updown_counter_mod_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MIN_VAL   = '0,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               SATURATE  = MODE_WRAP
`ifdef UPDOWN_COUNTER_MOD_PRESCALE_EN
    ,
    parameter int               PRESCALE  = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             event_pulse
);

    localparam int               PAD   = CLAMP_W - WIDTH;
    localparam logic [WIDTH:0]   MIN_X = {1'b0, MIN_VAL};
    localparam logic [WIDTH:0]   MAX_X = {1'b0, MAX_VAL};

    logic [WIDTH-1:0] r_count;
    logic             r_event;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_event_nxt;
    logic             w_step;
    logic [WIDTH:0]   w_count_x;
    logic [WIDTH:0]   w_inc_x;
    logic [WIDTH:0]   w_dec_x;
    logic             w_up_bound;
    logic             w_dn_bound;
    clamp_e           w_clamp;

    // ------------------------------------------------------------------
    // Step qualifier: every enabled cycle, or the prescaler tick
    // ------------------------------------------------------------------
`ifdef UPDOWN_COUNTER_MOD_PRESCALE_EN
    logic r_dir;
    logic w_pre_clr;

    // Any control action or a direction change restarts the prescale phase
    assign w_pre_clr = clear | load | (up_down != r_dir);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dir <= DIR_UP;
        end else begin
            r_dir <= up_down;
        end
    end

    udcnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (w_pre_clr),
        .en    (en),
        .tick  (w_step)
    );
`else
    assign w_step = en;
`endif

    // ------------------------------------------------------------------
    // Bound detection in WIDTH+1 bits so non-power-of-2 ranges and
    // MAX_VAL = 2**WIDTH-1 never rely on modulo wrap of the register.
    // ------------------------------------------------------------------
    assign w_count_x  = {1'b0, r_count};
    assign w_inc_x    = w_count_x + {{WIDTH{1'b0}}, 1'b1};
    assign w_dec_x    = w_count_x - {{WIDTH{1'b0}}, 1'b1};
    assign w_up_bound = (w_inc_x > MAX_X);
    // Borrow out of the MSB means the count was already 0
    assign w_dn_bound = w_dec_x[WIDTH] | (w_dec_x < MIN_X);

    assign w_clamp = clamp_sel({{PAD{1'b0}}, load_val},
                               {{PAD{1'b0}}, MIN_VAL},
                               {{PAD{1'b0}}, MAX_VAL});

    // ------------------------------------------------------------------
    // Next-state: clear > load > step
    // ------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        w_event_nxt = 1'b0;
        if (clear) begin
            w_count_nxt = RESET_VAL;
        end else if (load) begin
            case (w_clamp)
                CLAMP_TO_MAX: w_count_nxt = MAX_VAL;
                CLAMP_TO_MIN: w_count_nxt = MIN_VAL;
                default:      w_count_nxt = load_val;
            endcase
        end else if (w_step) begin
            case (up_down)
                DIR_UP: begin
                    if (w_up_bound) begin
                        w_event_nxt = 1'b1;
                        if (SATURATE == MODE_WRAP) begin
                            w_count_nxt = MIN_VAL;
                        end
                    end else begin
                        w_count_nxt = w_inc_x[WIDTH-1:0];
                    end
                end
                DIR_DOWN: begin
                    if (w_dn_bound) begin
                        w_event_nxt = 1'b1;
                        if (SATURATE == MODE_WRAP) begin
                            w_count_nxt = MAX_VAL;
                        end
                    end else begin
                        w_count_nxt = w_dec_x[WIDTH-1:0];
                    end
                end
                default: begin
                    w_count_nxt = r_count;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= RESET_VAL;
            r_event <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_event <= w_event_nxt;
        end
    end

    assign count       = r_count;
    assign event_pulse = r_event;
    assign at_max      = (w_count_x == MAX_X);
    assign at_min      = (w_count_x == MIN_X);

endmodule
`default_nettype wire

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Parametrised successor to the team's 4-bit up/down counter.
- Adds configurable width and range [MIN_VAL..MAX_VAL], wrap or saturate mode, count enable, synchronous clear and parallel load.
- Adds terminal-count flags and a registered wrap/saturation event pulse.
- Used as a generic timer, address or credit counter in the datapath and control blocks.

Parameters:
WIDTH, 8, counter width in bits (2..32)
MIN_VAL, 0, lower bound of count range
MAX_VAL, 2**WIDTH-1, upper bound of count range; must satisfy MIN_VAL < MAX_VAL <= 2**WIDTH-1
RESET_VAL, 0, value after reset; must lie in [MIN_VAL..MAX_VAL]
SATURATE, 0, 0 = wrap at bounds, 1 = saturate (hold) at bounds

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous clear to RESET_VAL
load  in  1  synchronous parallel load
load_val  in  WIDTH  value for load
en  in  1  count enable
up_down  in  1  1 = increment, 0 = decrement
count  out  WIDTH  registered count value
at_max  out  1  count == MAX_VAL (combinational decode of count)
at_min  out  1  count == MIN_VAL (combinational decode of count)
event_pulse  out  1  registered one-cycle pulse on wrap (SATURATE=0) or on a blocked step at a bound (SATURATE=1)

Behaviour:
- Reset (async, active-high): count=RESET_VAL, event_pulse=0. at_max and at_min follow count. Release takes effect at the next clk edge.
- Priority per cycle: clear > load > en. With none active, count holds and event_pulse=0.
- clear: count<=RESET_VAL next edge; event_pulse<=0.
- load: count<=load_val, clamped into the range.
  - load_val > MAX_VAL loads MAX_VAL; load_val < MIN_VAL loads MIN_VAL.
  - event_pulse<=0.
  - en and up_down are ignored in a load cycle.
- en=1, up_down=1:
  - count<MAX_VAL: count+1.
  - count==MAX_VAL: SATURATE=0 gives count<=MIN_VAL and event_pulse<=1; SATURATE=1 gives count holds and event_pulse<=1.
- en=1, up_down=0:
  - count>MIN_VAL: count-1.
  - count==MIN_VAL: SATURATE=0 gives count<=MAX_VAL and event_pulse<=1; SATURATE=1 gives count holds and event_pulse<=1.
- Latency: one clk from input to count and event_pulse. at_max/at_min valid in the same cycle as count.
- Arithmetic: compare/increment in WIDTH+1 bits internally. No reliance on natural modulo-2^WIDTH wrap, so non-power-of-2 ranges work.
- Direction change mid-count: takes effect on the next enabled edge, no dead cycle.
- Reset mid-operation: immediate; pending load/clear discarded.
- event_pulse is never asserted for two cycles from one event. It is asserted again on consecutive cycles only if consecutive bound events occur (e.g. saturated with en held).

Optional Feature:
UPDOWN_COUNTER_MOD_PRESCALE_EN
- Defined:
  - Adds parameter PRESCALE (default 4, >=1) and an internal prescale counter.
  - The count steps only on every PRESCALE-th cycle with en=1; event_pulse is produced only on such a step.
  - The prescaler advances only while en=1.
  - The prescaler resets to 0 on reset, clear, load, or an up_down change.
- Not defined: count steps on every en=1 cycle, and no prescaler logic or parameter exists.

Decomposition:
- Package updown_counter_mod_pkg:
  - mode constants MODE_WRAP=0 and MODE_SAT=1;
  - direction constants DIR_UP=1 and DIR_DOWN=0;
  - a clamp function for load_val.
- Sub-module udcnt_prescaler (tick generator with en/sync-clear, output tick) is instantiated only under UPDOWN_COUNTER_MOD_PRESCALE_EN.
- Next-state logic and registers are otherwise single-module.

Test Plan:
- WIDTH=4, MIN=2, MAX=9, RESET_VAL=2, SATURATE=0, up, en=1 for 9 cycles: count 3,4,...,9,2,3; event_pulse=1 only in the cycle count shows 2. at_max=1 while count=9.
- Same config, down from 2: next count=9 with event_pulse=1; then 8,7.
- SATURATE=1, count=9, up with en=1 for 3 cycles: count stays 9; event_pulse=1 each cycle. Switching to down gives 8, event_pulse=0.
- load_val=15 gives count=9; load_val=0 gives count=2; load_val=5 gives 5. load+en+up together: count=load value, no increment. clear+load together: count=RESET_VAL.
- Async reset asserted mid-count (count=7) between edges: count=2 immediately, event_pulse=0. Normal counting resumes at the first edge after release.
- With UPDOWN_COUNTER_MOD_PRESCALE_EN, PRESCALE=3, en=1, up from 2: count changes every 3rd cycle (2,2,3,3,3,4...). Toggling up_down restarts the prescale phase.
